// File: rtl/divider_datapath.sv
// Restoring radix-2 unsigned divider for CDF normalization.
// Build option: DIVIDER_ROUND_EN selects round-to-nearest quotient.
module divider_datapath #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sc_mem_rd_data_rdy,
  input  logic [DATA_W-1:0] sc_mem_rd_data1,
  input  logic [DATA_W-1:0] sc_mem_rd_data2,
  output logic [DATA_W-1:0] sc_mem_wt_data,
  output logic [DATA_W-1:0] div_remainder,
  output logic              div_done,
  output logic              div_busy,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;

  logic [DATA_W:0]   partial;
  logic [DATA_W:0]   dvs_ext;
  logic              q_bit;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] dvd_nxt;
  logic [DATA_W-1:0] q_fin;
  logic              start;
  logic              last;

  assign start = (state == IDLE) &&
                 sc_mem_rd_data_rdy;
  assign last  = (state == CALC) &&
                 (cnt == LAST);
  assign div_busy = (state != IDLE);

  // One restoring step: quotient bits shift
  // into the dividend register from the LSB.
  always_comb begin
    partial = {rem, dvd[DATA_W-1]};
    dvs_ext = {1'b0, dvs};
    q_bit   = (partial >= dvs_ext);
    rem_nxt = partial[DATA_W-1:0];
    if (q_bit)
      rem_nxt = DATA_W'(partial - dvs_ext);
    dvd_nxt = {dvd[DATA_W-2:0], q_bit};
  end

`ifdef DIVIDER_ROUND_EN
  logic rnd_up;

  // Round half up; zero divisor and an
  // all-ones quotient are left untouched.
  always_comb begin
    rnd_up = (dvs != '0) &&
             ({rem_nxt, 1'b0} >= dvs_ext);
    q_fin  = dvd_nxt;
    if (rnd_up && !(&dvd_nxt))
      q_fin = dvd_nxt + 1'b1;
  end
`else
  // Truncating quotient.
  always_comb begin
    q_fin = dvd_nxt;
  end
`endif

  // Control FSM and step counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            state <= CALC;
            cnt   <= '0;
          end
        end
        (state == CALC): begin
          if (last)
            state <= DONE;
          else
            cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Operand and partial-remainder registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
    end else if (start) begin
      dvd <= sc_mem_rd_data1;
      dvs <= sc_mem_rd_data2;
      rem <= '0;
    end else if (state == CALC) begin
      dvd <= dvd_nxt;
      rem <= rem_nxt;
    end
  end

  // Results update only at completion;
  // the zero flag also refreshes at start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc_mem_wt_data <= '0;
      div_remainder  <= '0;
      div_done       <= 1'b0;
      div_by_zero    <= 1'b0;
    end else begin
      div_done <= last;
      if (start)
        div_by_zero <= (sc_mem_rd_data2 == '0);
      if (last) begin
        sc_mem_wt_data <= q_fin;
        div_remainder  <= rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_divider_datapath.sv
// Directed self-checking bench for divider_datapath.
// Build option: DIVIDER_ROUND_EN changes rounded expectations.
module tb_divider_datapath;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [15:0] d1;
  logic [15:0] d2;
  logic [15:0] wt;
  logic [15:0] rm;
  logic        done;
  logic        busy;
  logic        dz;

  int vecs;
  int errs;

`ifdef DIVIDER_ROUND_EN
  localparam logic [15:0] Q_7_9   = 16'd1;
  localparam logic [15:0] Q_500_3 = 16'd167;
  localparam logic [15:0] Q_20_8  = 16'd3;
`else
  localparam logic [15:0] Q_7_9   = 16'd0;
  localparam logic [15:0] Q_500_3 = 16'd166;
  localparam logic [15:0] Q_20_8  = 16'd2;
`endif

  divider_datapath #(.DATA_W(16)) dut (
    .clk                (clk),
    .reset              (rst_n),
    .sc_mem_rd_data_rdy (rdy),
    .sc_mem_rd_data1    (d1),
    .sc_mem_rd_data2    (d2),
    .sc_mem_wt_data     (wt),
    .div_remainder      (rm),
    .div_done           (done),
    .div_busy           (busy),
    .div_by_zero        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] a,
                       input logic [15:0] b);
    rdy = 1'b1;
    d1  = a;
    d2  = b;
    step();
    rdy = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdy   = 1'b0;
    d1    = '0;
    d2    = '0;
    step();
    step();
    vecs++;
    if ({wt, rm, done, busy, dz} !== '0) begin
      errs++;
      $display("FAIL reset_hold: got %h/%h %b%b%b want 0",
               wt, rm, done, busy, dz);
    end
    rst_n = 1'b1;
    step();
    vecs++;
    if ({wt, rm, done, busy, dz} !== '0) begin
      errs++;
      $display("FAIL reset_rel: got %h/%h %b%b%b want 0",
               wt, rm, done, busy, dz);
    end
  endtask

  task automatic test_basic();
    int n;
    logic bad;
    start(16'd100, 16'd7);
    bad = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      if (!busy || done || wt !== 16'd0) bad = 1'b1;
    end
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL basic_calc: busy/done/wt wrong during CALC");
    end
    step();
    vecs++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL basic_latency: done=%b want 1 at edge 16", done);
    end
    vecs++;
    if (wt !== 16'd14 || rm !== 16'd2 || dz !== 1'b0) begin
      errs++;
      $display("FAIL basic_result: got %0d r%0d z%b want 14 r2 z0",
               wt, rm, dz);
    end
    step();
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_pulse: done=%b busy=%b want 0 0",
               done, busy);
    end
  endtask

  task automatic test_div_zero();
    int n;
    start(16'd5, 16'd0);
    wait_done(n);
    vecs++;
    if (n != 16 || wt !== 16'hFFFF || rm !== 16'd5 || dz !== 1'b1) begin
      errs++;
      $display("FAIL div_zero: n=%0d got %h r%0d z%b want 16 ffff r5 z1",
               n, wt, rm, dz);
    end
    step();
    start(16'd9, 16'd3);
    vecs++;
    if (dz !== 1'b0) begin
      errs++;
      $display("FAIL dz_clear: got %b want 0", dz);
    end
    wait_done(n);
    vecs++;
    if (n != 16 || wt !== 16'd3 || rm !== 16'd0) begin
      errs++;
      $display("FAIL div_9_3: n=%0d got %0d r%0d want 16 3 r0",
               n, wt, rm);
    end
    step();
  endtask

  task automatic test_busy_reject();
    int cnt;
    start(16'hFFFF, 16'd1);
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) begin
        rdy = 1'b1;
        d1  = 16'd9;
        d2  = 16'd3;
      end
      step();
      rdy = 1'b0;
    end
    vecs++;
    if (done !== 1'b1 || wt !== 16'hFFFF || rm !== 16'd0) begin
      errs++;
      $display("FAIL busy_rej: done=%b got %h r%0d want 1 ffff r0",
               done, wt, rm);
    end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL busy_done_rdy: done=%b busy=%b want 0 0",
               done, busy);
    end
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done || busy) cnt++;
    end
    vecs++;
    if (cnt != 0 || wt !== 16'hFFFF) begin
      errs++;
      $display("FAIL busy_queued: active=%0d wt=%h want 0 ffff",
               cnt, wt);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic bad;
    start(16'd1000, 16'd10);
    wait_done(n);
    vecs++;
    if (n != 16 || wt !== 16'd100 || rm !== 16'd0) begin
      errs++;
      $display("FAIL b2b_first: n=%0d got %0d r%0d want 16 100 r0",
               n, wt, rm);
    end
    step();
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle: busy=%b want 0", busy);
    end
    start(16'd7, 16'd9);
    bad = 1'b0;
    n = 0;
    while (n < 40) begin
      if (!busy) bad = 1'b1;
      step();
      n++;
      if (done) break;
    end
    vecs++;
    if (n != 16 || bad || busy !== 1'b1) begin
      errs++;
      $display("FAIL b2b_spacing: n=%0d busy_gap=%b want 16 0",
               n, bad);
    end
    vecs++;
    if (wt !== Q_7_9 || rm !== 16'd7) begin
      errs++;
      $display("FAIL b2b_second: got %0d r%0d want %0d r7",
               wt, rm, Q_7_9);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int n;
    int cnt;
    start(16'd500, 16'd3);
    for (int i = 1; i < 8; i++) step();
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({wt, rm, done, busy, dz} !== '0) begin
      errs++;
      $display("FAIL mid_reset: got %h/%h %b%b%b want 0",
               wt, rm, done, busy, dz);
    end
    step();
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy) cnt++;
    end
    vecs++;
    if (cnt != 0) begin
      errs++;
      $display("FAIL mid_abort: active=%0d want 0", cnt);
    end
    start(16'd500, 16'd3);
    wait_done(n);
    vecs++;
    if (n != 16 || wt !== Q_500_3 || rm !== 16'd2) begin
      errs++;
      $display("FAIL mid_redo: n=%0d got %0d r%0d want 16 %0d r2",
               n, wt, rm, Q_500_3);
    end
    step();
  endtask

  task automatic test_round();
    int n;
    start(16'd20, 16'd8);
    wait_done(n);
    vecs++;
    if (n != 16 || wt !== Q_20_8 || rm !== 16'd4) begin
      errs++;
      $display("FAIL round_20_8: n=%0d got %0d r%0d want 16 %0d r4",
               n, wt, rm, Q_20_8);
    end
    step();
    start(16'd100, 16'd7);
    wait_done(n);
    vecs++;
    if (n != 16 || wt !== 16'd14 || rm !== 16'd2) begin
      errs++;
      $display("FAIL round_100_7: n=%0d got %0d r%0d want 16 14 r2",
               n, wt, rm);
    end
    step();
    start(16'hFFFF, 16'd0);
    wait_done(n);
    vecs++;
    if (n != 16 || wt !== 16'hFFFF || rm !== 16'hFFFF || dz !== 1'b1) begin
      errs++;
      $display("FAIL round_dz: n=%0d got %h r%h z%b want ffff ffff 1",
               n, wt, rm, dz);
    end
    step();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_op();
    test_round();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
